// File: rtl/binary_to_excess3_pkg.sv
// Shared constants and types for the binary to Excess-3 converter.
package binary_to_excess3_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  // Excess-3 is plain binary offset by three.
  localparam nibble_t XS3_OFFSET = 4'd3;

  // Largest nibble value that is a legal BCD digit.
  localparam nibble_t BCD_MAX = 4'd9;

endpackage : binary_to_excess3_pkg

// File: rtl/binary_to_excess3_xs3_digit.sv
// Single-nibble combinational Excess-3 converter.
// Optional macro BIN2XS3_BCD_CHECK_EN enables the non-BCD flag; otherwise
// the flag is tied low.
module xs3_digit
  import binary_to_excess3_pkg::*;
(
  input  nibble_t nibble,
  output nibble_t sum,
  output logic    carry,
  output logic    bcd_err
);

  logic [NIBBLE_W:0] full;

  // Zero-extended +3 add; bit 4 is the nibble's own carry-out.
  always_comb begin
    full    = {1'b0, nibble} + {1'b0, XS3_OFFSET};
    sum     = full[NIBBLE_W-1:0];
    carry   = full[NIBBLE_W];
`ifdef BIN2XS3_BCD_CHECK_EN
    bcd_err = (nibble > BCD_MAX);
`else
    bcd_err = 1'b0;
`endif
  end

endmodule : xs3_digit

// File: rtl/binary_to_excess3.sv
// Registered multi-digit binary to Excess-3 converter, one-cycle latency.
// Optional macro BIN2XS3_BCD_CHECK_EN registers a per-nibble "input > 9"
// flag on bcd_err; with the macro undefined bcd_err stays 0.
module binary_to_excess3
  import binary_to_excess3_pkg::*;
#(
  parameter int unsigned DIGITS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [NIBBLE_W*DIGITS-1:0] binary,
  output logic                       out_valid,
  output logic [NIBBLE_W*DIGITS-1:0] excess3,
  output logic [DIGITS-1:0]          carry,
  output logic [DIGITS-1:0]          bcd_err
);

  logic [NIBBLE_W*DIGITS-1:0] sum_d;
  logic [DIGITS-1:0]          carry_d;
  logic [DIGITS-1:0]          err_d;

  // Independent per-nibble converters: no carry chains between digits.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    xs3_digit u_digit (
      .nibble  (binary[NIBBLE_W*k +: NIBBLE_W]),
      .sum     (sum_d[NIBBLE_W*k +: NIBBLE_W]),
      .carry   (carry_d[k]),
      .bcd_err (err_d[k])
    );
  end

  // Valid pipeline; results load only on a sampled in_valid and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      excess3   <= '0;
      carry     <= '0;
      bcd_err   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        excess3 <= sum_d;
        carry   <= carry_d;
        bcd_err <= err_d;
      end
    end
  end

endmodule : binary_to_excess3

// File: tb/tb_binary_to_excess3.sv
// Directed bench for binary_to_excess3: table-driven single-digit vectors
// plus a hand-written two-digit sequence.
module tb_binary_to_excess3;

`ifdef BIN2XS3_BCD_CHECK_EN
  localparam bit BCD_EN = 1'b1;
`else
  localparam bit BCD_EN = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic       iv;
    logic [3:0] bin;
    logic       ev;
    logic [3:0] ex;
    logic       ec;
    logic       ee;   // flag value when the BCD check is built in
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, in_valid;
  logic [3:0] binary;
  logic       out_valid;
  logic [3:0] excess3;
  logic [0:0] carry, bcd_err;

  logic       rst2, in_valid2;
  logic [7:0] binary2;
  logic       out_valid2;
  logic [7:0] excess3_2;
  logic [1:0] carry2, bcd_err2;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  vec_t        tbl [29];

  always #5 clk = ~clk;

  binary_to_excess3 #(.DIGITS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .binary(binary),
    .out_valid(out_valid), .excess3(excess3), .carry(carry), .bcd_err(bcd_err)
  );

  binary_to_excess3 #(.DIGITS(2)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .binary(binary2),
    .out_valid(out_valid2), .excess3(excess3_2), .carry(carry2), .bcd_err(bcd_err2)
  );

  function automatic vec_t mk(logic r, logic iv, logic [3:0] b,
                              logic ev, logic [3:0] ex, logic ec, logic ee);
    vec_t v;
    v.rst = r; v.iv = iv; v.bin = b; v.ev = ev; v.ex = ex; v.ec = ec; v.ee = ee;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  initial begin
    // rst iv bin  -> valid xs3 carry err
    tbl[0]  = mk(1, 1, 4'h5, 0, 4'h0, 0, 0);
    tbl[1]  = mk(1, 1, 4'h5, 0, 4'h0, 0, 0);
    tbl[2]  = mk(0, 1, 4'h0, 1, 4'h3, 0, 0);
    tbl[3]  = mk(0, 1, 4'h1, 1, 4'h4, 0, 0);
    tbl[4]  = mk(0, 1, 4'h2, 1, 4'h5, 0, 0);
    tbl[5]  = mk(0, 1, 4'h3, 1, 4'h6, 0, 0);
    tbl[6]  = mk(0, 1, 4'h4, 1, 4'h7, 0, 0);
    tbl[7]  = mk(0, 1, 4'h5, 1, 4'h8, 0, 0);
    tbl[8]  = mk(0, 1, 4'h6, 1, 4'h9, 0, 0);
    tbl[9]  = mk(0, 1, 4'h7, 1, 4'hA, 0, 0);
    tbl[10] = mk(0, 1, 4'h8, 1, 4'hB, 0, 0);
    tbl[11] = mk(0, 1, 4'h9, 1, 4'hC, 0, 0);
    tbl[12] = mk(0, 1, 4'hA, 1, 4'hD, 0, 1);
    tbl[13] = mk(0, 1, 4'hB, 1, 4'hE, 0, 1);
    tbl[14] = mk(0, 1, 4'hC, 1, 4'hF, 0, 1);
    tbl[15] = mk(0, 1, 4'hD, 1, 4'h0, 1, 1);
    tbl[16] = mk(0, 1, 4'hE, 1, 4'h1, 1, 1);
    tbl[17] = mk(0, 1, 4'hF, 1, 4'h2, 1, 1);
    // hold: 2 loads, then idle cycles with garbage on binary
    tbl[18] = mk(0, 1, 4'h2, 1, 4'h5, 0, 0);
    tbl[19] = mk(0, 0, 4'hF, 0, 4'h5, 0, 0);
    tbl[20] = mk(0, 0, 4'hF, 0, 4'h5, 0, 0);
    // mid-stream reset on the edge that samples 3
    tbl[21] = mk(0, 1, 4'h1, 1, 4'h4, 0, 0);
    tbl[22] = mk(0, 1, 4'h2, 1, 4'h5, 0, 0);
    tbl[23] = mk(1, 1, 4'h3, 0, 4'h0, 0, 0);
    tbl[24] = mk(0, 0, 4'h0, 0, 4'h0, 0, 0);
    tbl[25] = mk(0, 1, 4'h4, 1, 4'h7, 0, 0);
    // BCD flag set by A, held while idle, cleared by 9
    tbl[26] = mk(0, 1, 4'hA, 1, 4'hD, 0, 1);
    tbl[27] = mk(0, 0, 4'h9, 0, 4'hD, 0, 1);
    tbl[28] = mk(0, 1, 4'h9, 1, 4'hC, 0, 0);

    rst = 1'b1; in_valid = 1'b0; binary = '0;
    rst2 = 1'b1; in_valid2 = 1'b0; binary2 = '0;

    foreach (tbl[i]) begin
      rst = tbl[i].rst; in_valid = tbl[i].iv; binary = tbl[i].bin;
      @(posedge clk); #1;
      check("out_valid", i, {7'd0, out_valid}, {7'd0, tbl[i].ev});
      check("excess3",   i, {4'd0, excess3},   {4'd0, tbl[i].ex});
      check("carry",     i, {7'd0, carry},     {7'd0, tbl[i].ec});
      check("bcd_err",   i, {7'd0, bcd_err},   {7'd0, tbl[i].ee & BCD_EN});
    end

    // Two-digit instance: reset state, then independent nibbles
    @(posedge clk); #1;
    check("d2_rst_valid", 0, {7'd0, out_valid2}, 8'h00);
    check("d2_rst_xs3",   0, excess3_2, 8'h00);
    rst2 = 1'b0; in_valid2 = 1'b1; binary2 = 8'h9F;
    @(posedge clk); #1;
    check("d2_valid", 1, {7'd0, out_valid2}, 8'h01);
    check("d2_xs3",   1, excess3_2, 8'hC2);
    check("d2_carry", 1, {6'd0, carry2}, 8'h01);
    check("d2_err",   1, {6'd0, bcd_err2}, BCD_EN ? 8'h01 : 8'h00);
    binary2 = 8'hD0;
    @(posedge clk); #1;
    check("d2_xs3",   2, excess3_2, 8'h03);
    check("d2_carry", 2, {6'd0, carry2}, 8'h02);
    check("d2_err",   2, {6'd0, bcd_err2}, BCD_EN ? 8'h02 : 8'h00);
    in_valid2 = 1'b0; binary2 = 8'h55;
    @(posedge clk); #1;
    check("d2_hold_valid", 3, {7'd0, out_valid2}, 8'h00);
    check("d2_hold_xs3",   3, excess3_2, 8'h03);
    check("d2_hold_carry", 3, {6'd0, carry2}, 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_binary_to_excess3
